gpio_edge_irq: RTL and testbench
================================

# gpio_edge_irq

Input-conditioning and interrupt stage directly downstream of the GPIO pad block. It takes the raw per-pin read-back word (`data_o` of the GPIO block) and resynchronises each pin into `clk`. It debounces each pin, detects rising and falling edges under per-pin enable masks, and latches them into a sticky write-1-to-clear status word that drives a single level interrupt.

## Interface

Parameters:
- `WIDTH`, default 2: number of active pins, 1..32. Matches the GPIO block's pin count.
- `DEB_CYCLES`, default 16: consecutive stable cycles required before a level change is accepted, ≥1. Used only with debounce compiled in.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pin_i` in 32: raw pin levels from the GPIO read-back. Bits ≥ `WIDTH` are ignored.
- `rise_en` in 32: per-pin rising-edge interrupt enable.
- `fall_en` in 32: per-pin falling-edge interrupt enable.
- `clr` in 32: status bits to clear, write-1-to-clear.
- `clr_valid` in 1: qualifies `clr` for one cycle.
- `level_o` out 32: debounced pin levels. Bits ≥ `WIDTH` read as 0.
- `status_o` out 32: sticky edge status. Bits ≥ `WIDTH` read as 0.
- `irq` out 1: OR of `status_o`, registered.

## Operation

- Synchroniser: two flops per pin, `s1 <= pin_i[i]`, `s2 <= s1`. No logic between the two flops.
- Debounce, per pin:
  - Counter width is `$clog2(DEB_CYCLES+1)`.
  - If `s2 == level`: the counter goes to 0.
  - Else if `cnt == DEB_CYCLES-1`: `level <= s2` and `cnt <= 0`.
  - Else: `cnt++`.
  - Any return to the old level before acceptance discards the count. Glitches shorter than `DEB_CYCLES` cycles produce no change.
- Edge detect, combinational on the accepted update:
  - `rise = level_next & ~level`
  - `fall = ~level_next & level`
- Status update each cycle: `status <= (status & ~(clr & {32{clr_valid}})) | (rise & rise_en) | (fall & fall_en)`.
  - Set has priority over clear in the same cycle. An edge landing on the clear cycle keeps the bit at 1.
  - Changing `rise_en`/`fall_en` does not alter bits already set. Masks gate only new events.
- `irq <= |status_next`. `irq` and `status_o` always agree on the same edge.
- No state machine beyond the per-pin counters. All pins operate independently and in parallel.

## Timing

- Reset (async assert, sync use after release): `s1`, `s2`, `level_o`, counters, `status_o` = 0; `irq` = 0.
  - A pin held high through reset reports a rising edge after release once debounced.
  - Software keeps `rise_en` = 0 until settle time elapses if that is unwanted.
- Latency, counting edge 1 as the first edge sampling the new `pin_i` value:
  - `s2` valid after edge 2.
  - `level_o`, `status_o` and `irq` update at edge 2+`DEB_CYCLES`.
- Clear latency: `status_o` and `irq` drop at the edge that samples `clr_valid`=1, unless re-set that cycle.
- Reset mid-debounce: the count is lost, `level` = 0, and the process restarts from scratch.
- Bits ≥ `WIDTH` have no flops and are tied 0 on all outputs.

## Configuration

- Macro: `GPIO_DEBOUNCE_EN`.
- Defined: debounce counters as described; `level` updates at edge 2+`DEB_CYCLES`.
- Undefined: no counters; `level <= s2` every cycle, so `level_o` updates at edge 3. `DEB_CYCLES` is ignored. Edge, status and irq behaviour is otherwise identical.

## Test plan

Settings for all scenarios: `WIDTH`=2, `DEB_CYCLES`=4, `GPIO_DEBOUNCE_EN` defined.

1. Assert `rst_n`=0 mid-run with `pin_i`=32'h3 -> all outputs 0 immediately. After release with `rise_en`=0, `level_o`=32'h3 at edge 6 and `status_o` stays 0.
2. `rise_en`=1, `pin_i[0]` 0→1 held -> `level_o[0]`, `status_o[0]` and `irq` go to 1 at edge 6, none earlier.
3. `pin_i[1]` high for 3 cycles then low, `rise_en`=2 -> `level_o[1]`, `status_o[1]` and `irq` stay 0 throughout.
4. With `status_o`=1: `clr_valid`=1, `clr`=1 -> `status_o` and `irq` are 0 at the next edge. Repeat with a pin-0 rising edge accepted in the clear cycle -> `status_o[0]` stays 1.
5. `fall_en`=0, `pin_i[0]` 1→0 held -> `level_o[0]`=0 at edge 6 and `status_o` unchanged. Repeat with `fall_en`=1 -> `status_o[0]`=1.
6. Toggle `pin_i[5]` and `pin_i[31]` with all enables set -> `level_o`, `status_o` and `irq` remain 0. Then rebuild without the macro and repeat scenario 2 -> update at edge 3.

Source files
------------

// File: rtl/gpio_edge_irq.sv
// gpio_edge_irq: per-pin resynchronisation, optional debounce, rising/falling
// edge detection under enable masks, sticky write-1-to-clear status and a
// registered level interrupt.
//
// Build option: define GPIO_DEBOUNCE_EN to insert the per-pin debounce
// counters. Without it the debounced level simply follows the synchroniser.
module gpio_edge_irq #(
    parameter int WIDTH      = 2,
    parameter int DEB_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pin_i,
    input  logic [31:0] rise_en,
    input  logic [31:0] fall_en,
    input  logic [31:0] clr,
    input  logic        clr_valid,
    output logic [31:0] level_o,
    output logic [31:0] status_o,
    output logic        irq
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] level_next;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] status;
    logic [WIDTH-1:0] status_next;

    // Two-flop synchroniser per pin, nothing between the stages.
    // NOTE: every sequential block uses <= so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pin_i[WIDTH-1:0];
            s2 <= s1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] accept;

    // A pin's new level is accepted once it has differed for DEB_CYCLES samples.
    // NOTE: always_comb assigns every output on every path, so no latch is inferred.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (s2[i] != level[i]) && (cnt[i] == CNT_LAST);
        end
        level_next = level ^ accept;
    end

    // Per-pin stability counters; any return to the held level restarts the count.
    // NOTE: the counter array is reset explicitly because a reset mid-debounce must discard the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign level_next = s2;
`endif

    // Edge detection on the accepted update and sticky status with set-over-clear.
    always_comb begin
        rise        = level_next & ~level;
        fall        = ~level_next & level;
        clr_mask    = clr[WIDTH-1:0] & {WIDTH{clr_valid}};
        status_next = (status & ~clr_mask)
                    | (rise & rise_en[WIDTH-1:0])
                    | (fall & fall_en[WIDTH-1:0]);
    end

    // Level, status and irq registered together so irq always matches status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level  <= '0;
            status <= '0;
            irq    <= 1'b0;
        end else begin
            level  <= level_next;
            status <= status_next;
            irq    <= |status_next;
        end
    end

    assign level_o  = 32'(level);
    assign status_o = 32'(status);

    // Pins above WIDTH have no logic; fold their inputs into a sink.
    if (WIDTH < 32) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^{pin_i[31:WIDTH], rise_en[31:WIDTH],
                             fall_en[31:WIDTH], clr[31:WIDTH]};
    end

endmodule

// File: tb/tb_gpio_edge_irq.sv
// tb_gpio_edge_irq: table-driven vectors, hand-written timing sequences and
// randomized stimulus compared against a sliding-window reference model.
module tb_gpio_edge_irq;

    localparam int WIDTH = 2;
    localparam int DEB   = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int DEB_EFF = DEB;
`else
    localparam int DEB_EFF = 1;
`endif
    localparam int LAT  = DEB_EFF + 2;
    localparam int HOLD = LAT + 3;
    localparam logic [31:0] WMASK = (32'd1 << WIDTH) - 32'd1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pin, rise_en, fall_en, clr;
    logic        clr_valid;
    logic [31:0] level_o, status_o;
    logic        irq;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] hist [$];
    logic [31:0] m_level, m_status;
    logic        m_irq;

    typedef struct {
        logic [31:0] pin;
        logic [31:0] rise_en;
        logic [31:0] fall_en;
        logic [31:0] clr;
        logic        clr_valid;
        logic [31:0] exp_level;
        logic [31:0] exp_status;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [13];

    gpio_edge_irq #(.WIDTH(WIDTH), .DEB_CYCLES(DEB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pin_i    (pin),
        .rise_en  (rise_en),
        .fall_en  (fall_en),
        .clr      (clr),
        .clr_valid(clr_valid),
        .level_o  (level_o),
        .status_o (status_o),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int j = 0; j < DEB_EFF + 2; j++) hist.push_back('0);
        m_level  = '0;
        m_status = '0;
        m_irq    = 1'b0;
    endtask

    // A level flips when the synchronised pin (two samples old) has shown the
    // opposite value on each of the last DEB_EFF clock edges.
    task automatic model_step();
        logic [31:0] nl, rs, fl, cm;
        hist.push_front(pin & WMASK);
        if (hist.size() > DEB_EFF + 2) void'(hist.pop_back());
        nl = m_level;
        for (int i = 0; i < WIDTH; i++) begin
            bit flip = 1'b1;
            for (int j = 2; j < DEB_EFF + 2; j++) begin
                if (hist[j][i] == m_level[i]) flip = 1'b0;
            end
            if (flip) nl[i] = ~m_level[i];
        end
        rs = nl & ~m_level;
        fl = ~nl & m_level;
        cm = clr_valid ? clr : 32'd0;
        m_status = ((m_status & ~cm) | (rs & rise_en) | (fl & fall_en)) & WMASK;
        m_irq    = |m_status;
        m_level  = nl;
    endtask

    // One clock edge: advance the model, then compare away from the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_level", level_o, m_level);
        check("model_status", status_o, m_status);
        check("model_irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    // Pulse reset between clock edges; outputs must clear immediately.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_level", level_o, 32'd0);
        check("rst_status", status_o, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        pin = '0; rise_en = '0; fall_en = '0; clr = '0; clr_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'h8000_0020, 32'hffff_ffff, 32'hffff_ffff, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[1]  = '{32'h0,         32'hffff_ffff, 32'hffff_ffff, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[2]  = '{32'h1,         32'h1,         32'h0,         32'h0, 1'b0, 32'h1, 32'h1, 1'b1};
        vecs[3]  = '{32'h3,         32'h1,         32'h0,         32'h0, 1'b0, 32'h3, 32'h1, 1'b1};
        vecs[4]  = '{32'h3,         32'h1,         32'h0,         32'h1, 1'b1, 32'h3, 32'h0, 1'b0};
        vecs[5]  = '{32'h2,         32'h0,         32'h1,         32'h0, 1'b0, 32'h2, 32'h1, 1'b1};
        vecs[6]  = '{32'h0,         32'h0,         32'h3,         32'h0, 1'b0, 32'h0, 32'h3, 1'b1};
        vecs[7]  = '{32'h0,         32'h0,         32'h3,         32'h2, 1'b1, 32'h0, 32'h1, 1'b1};
        vecs[8]  = '{32'h0,         32'h0,         32'h3,         32'hffff_ffff, 1'b1, 32'h0, 32'h0, 1'b0};
        vecs[9]  = '{32'h3,         32'h2,         32'h0,         32'h0, 1'b0, 32'h3, 32'h2, 1'b1};
        vecs[10] = '{32'h3,         32'hffff_ffff, 32'h0,         32'h0, 1'b0, 32'h3, 32'h2, 1'b1};
        vecs[11] = '{32'h3,         32'h0,         32'h0,         32'h0, 1'b0, 32'h3, 32'h2, 1'b1};
        vecs[12] = '{32'h1,         32'h0,         32'h0,         32'h0, 1'b0, 32'h1, 32'h2, 1'b1};

        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #7 rst_n = 1'b1;

        // Reset mid-run with pins high; rising edge reported only if enabled.
        pin = 32'h3;
        for (int k = 0; k < LAT + 2; k++) tick();
        check("pre_rst_level", level_o, 32'h3);
        do_reset();
        for (int k = 1; k <= LAT; k++) begin
            tick();
            check("s1_level", level_o, (k < LAT) ? 32'h0 : 32'h3);
            check("s1_status", status_o, 32'h0);
        end

        // Rising edge on pin 0 with exact latency.
        idle_inputs();
        do_reset();
        tick(); tick();
        rise_en = 32'h1;
        pin     = 32'h1;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            check("s2_level", level_o, (k < LAT) ? 32'h0 : 32'h1);
            check("s2_status", status_o, (k < LAT) ? 32'h0 : 32'h1);
            check("s2_irq", {31'd0, irq}, (k < LAT) ? 32'h0 : 32'h1);
        end

        // Clear, then clear coinciding with an accepted rising edge.
        clr = 32'h1; clr_valid = 1'b1;
        tick();
        check("s4_clr_status", status_o, 32'h0);
        check("s4_clr_irq", {31'd0, irq}, 32'h0);
        clr_valid = 1'b0;
        fall_en = 32'h1; pin = 32'h0;
        for (int k = 0; k < LAT; k++) tick();
        check("s4_fall_status", status_o, 32'h1);
        rise_en = 32'h1; fall_en = 32'h0; pin = 32'h1;
        for (int k = 0; k < LAT - 1; k++) tick();
        clr_valid = 1'b1;
        tick();
        check("s4_setwin_status", status_o, 32'h1);
        check("s4_setwin_irq", {31'd0, irq}, 32'h1);
        tick();
        check("s4_clr2_status", status_o, 32'h0);
        clr_valid = 1'b0;

        // Falling edge masked, then enabled.
        rise_en = 32'h0; fall_en = 32'h0; pin = 32'h0;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            check("s5_level", level_o, (k < LAT) ? 32'h1 : 32'h0);
        end
        check("s5_status_masked", status_o, 32'h0);
        pin = 32'h1;
        for (int k = 0; k < LAT; k++) tick();
        fall_en = 32'h1; pin = 32'h0;
        for (int k = 0; k < LAT; k++) tick();
        check("s5_status_en", status_o, 32'h1);
        check("s5_irq_en", {31'd0, irq}, 32'h1);

`ifdef GPIO_DEBOUNCE_EN
        // Glitch shorter than the debounce window is rejected.
        idle_inputs();
        do_reset();
        rise_en = 32'h2; pin = 32'h2;
        for (int k = 0; k < 3; k++) tick();
        pin = 32'h0;
        for (int k = 0; k < LAT + 4; k++) begin
            tick();
            check("s3_level", level_o, 32'h0);
            check("s3_status", status_o, 32'h0);
            check("s3_irq", {31'd0, irq}, 32'h0);
        end
`endif

        // Table of steady-state vectors; each held long enough to settle.
        idle_inputs();
        do_reset();
        foreach (vecs[v]) begin
            pin       = vecs[v].pin;
            rise_en   = vecs[v].rise_en;
            fall_en   = vecs[v].fall_en;
            clr       = vecs[v].clr;
            clr_valid = vecs[v].clr_valid;
            tick();
            clr_valid = 1'b0;
            for (int k = 1; k < HOLD; k++) tick();
            check($sformatf("vec%0d_level", v), level_o, vecs[v].exp_level);
            check($sformatf("vec%0d_status", v), status_o, vecs[v].exp_status);
            check($sformatf("vec%0d_irq", v), {31'd0, irq}, {31'd0, vecs[v].exp_irq});
        end

        // Randomized traffic against the model, with one reset mid-stream.
        idle_inputs();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            if ($urandom_range(4) == 0) pin = pin ^ (32'd1 << $urandom_range(31));
            if ($urandom_range(15) == 0) rise_en = $urandom();
            if ($urandom_range(15) == 0) fall_en = $urandom();
            clr       = $urandom();
            clr_valid = ($urandom_range(7) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
